// File: rtl/issue_select_rs.sv
// issue_select_rs: age-ordered reservation station that wakes sources and issues the oldest ready uop into the issue FIFO
module issue_select_rs #(
    parameter int RS_DEPTH   = 8,
    parameter int TAG_W      = 6,
    parameter int PAYLOAD_W  = 64,
    parameter int WAKE_PORTS = 2,
    localparam int OW        = $clog2(RS_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [PAYLOAD_W-1:0]        disp_payload,
    input  logic [TAG_W-1:0]            disp_src1_tag,
    input  logic                        disp_src1_rdy,
    input  logic [TAG_W-1:0]            disp_src2_tag,
    input  logic                        disp_src2_rdy,
    input  logic [WAKE_PORTS-1:0]       wake_valid,
    input  logic [WAKE_PORTS*TAG_W-1:0] wake_tag,
    input  logic                        fifo_full,
    output logic                        issue_valid,
    output logic [PAYLOAD_W-1:0]        issue_payload,
    output logic [OW-1:0]               occupancy,
    output logic                        empty
);
    logic [RS_DEPTH-1:0]  valid, rdy1, rdy2, cand, blocked, sel, free, alloc_oh;
    logic [TAG_W-1:0]     tag1 [RS_DEPTH];
    logic [TAG_W-1:0]     tag2 [RS_DEPTH];
    logic [PAYLOAD_W-1:0] pay  [RS_DEPTH];
    logic [RS_DEPTH-1:0]  age  [RS_DEPTH];
    logic [PAYLOAD_W-1:0] win_pay;
    logic                 alloc;

    function automatic logic hit(input logic [TAG_W-1:0] t);
        hit = 1'b0;
        for (int p = 0; p < WAKE_PORTS; p++)
            hit = hit | (wake_valid[p] && wake_tag[p*TAG_W +: TAG_W] == t);
    endfunction

    assign disp_ready = ~&valid;
    assign alloc      = disp_valid && disp_ready && !flush;
    assign free       = ~valid;
    assign alloc_oh   = free & (-free);
    assign cand       = valid & rdy1 & rdy2;
    assign sel        = cand & ~blocked;
    assign issue_valid   = |cand && !fifo_full && !flush;
    assign issue_payload = issue_valid ? win_pay : '0;
    assign empty      = ~|valid;

    // an entry is blocked when any older entry is also a candidate
    always_comb begin
        blocked = '0;
        for (int i = 0; i < RS_DEPTH; i++)
            for (int j = 0; j < RS_DEPTH; j++)
                blocked[i] = blocked[i] | (cand[j] & age[j][i]);
    end

    always_comb begin
        win_pay   = '0;
        occupancy = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            win_pay   = win_pay | (sel[i] ? pay[i] : '0);
            occupancy = occupancy + OW'(valid[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            rdy1  <= '0;
            rdy2  <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                tag1[i] <= '0;
                tag2[i] <= '0;
                pay[i]  <= '0;
                age[i]  <= '0;
            end
        end else if (flush) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (valid[i] && hit(tag1[i])) rdy1[i] <= 1'b1;
                if (valid[i] && hit(tag2[i])) rdy2[i] <= 1'b1;
                if (issue_valid && sel[i]) valid[i] <= 1'b0;
                // the new entry is younger than every currently valid entry
                if (alloc)
                    age[i] <= alloc_oh[i] ? '0 : (age[i] & ~alloc_oh) | (valid[i] ? alloc_oh : '0);
                if (alloc && alloc_oh[i]) begin
                    valid[i] <= 1'b1;
                    rdy1[i]  <= disp_src1_rdy || hit(disp_src1_tag);
                    rdy2[i]  <= disp_src2_rdy || hit(disp_src2_tag);
                    tag1[i]  <= disp_src1_tag;
                    tag2[i]  <= disp_src2_tag;
                    pay[i]   <= disp_payload;
                end
            end
        end
    end
endmodule

// File: tb/tb_issue_select_rs.sv
// tb_issue_select_rs: scoreboard bench checking issue order and timing of issue_select_rs
module tb_issue_select_rs;
    logic        clk = 0, rst_n = 0, flush = 0, disp_valid = 0, disp_ready;
    logic [63:0] disp_payload = 0, issue_payload;
    logic [5:0]  disp_src1_tag = 0, disp_src2_tag = 0;
    logic        disp_src1_rdy = 0, disp_src2_rdy = 0, fifo_full = 0, issue_valid, empty;
    logic [1:0]  wake_valid = 0;
    logic [11:0] wake_tag = 0;
    logic [3:0]  occupancy;
    int          total = 0, bad = 0, cyc = 0, b;

    typedef struct {
        logic [63:0] p;
        int          c;
    } exp_t;
    exp_t q[$];

    issue_select_rs dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_payload(disp_payload), .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
        .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy), .wake_valid(wake_valid),
        .wake_tag(wake_tag), .fifo_full(fifo_full), .issue_valid(issue_valid),
        .issue_payload(issue_payload), .occupancy(occupancy), .empty(empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [63:0] p, input logic [5:0] t1, input logic r1,
                        input logic [5:0] t2, input logic r2, input bit push, input int ec);
        disp_valid = 1; disp_payload = p;
        disp_src1_tag = t1; disp_src1_rdy = r1;
        disp_src2_tag = t2; disp_src2_rdy = r2;
        if (push) q.push_back('{p, ec});
        tick;
        disp_valid = 0;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && q.size() != 0; i++) tick;
        chk("drain", 64'(q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && issue_valid) begin
            if (q.size() == 0) chk("spurious_issue", issue_valid, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("issue_payload", issue_payload, e.p);
                chk("issue_cycle", 64'(cyc), 64'(e.c));
            end
        end
    end

    initial begin
        #2;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_payload", issue_payload, 0);
        #10 rst_n = 1;
        tick;

        // back-to-back ready dispatch, plus alloc+issue in the same cycle
        b = cyc;
        disp(64'hA, 0, 1, 0, 1, 1, b + 1);
        disp(64'hB, 0, 1, 0, 1, 1, b + 2);
        chk("alloc_issue_occ", occupancy, 1);
        disp(64'hC, 0, 1, 0, 1, 1, b + 3);
        drain(5);

        // wakeup ordering: younger ready uop overtakes the waiting one
        tick;
        b = cyc;
        disp(64'h1A, 5, 0, 0, 1, 0, 0);
        disp(64'h1B, 0, 1, 0, 1, 1, b + 2);
        tick;
        wake_valid = 2'b01; wake_tag = 12'(5);
        q.push_back('{64'h1A, cyc + 1});
        tick;
        wake_valid = 0;
        drain(5);

        // same-cycle wake and dispatch on port 1
        tick;
        wake_valid = 2'b10; wake_tag = {6'd9, 6'd0};
        disp(64'h2A, 0, 1, 9, 0, 1, cyc + 1);
        wake_valid = 0; wake_tag = 0;
        drain(5);

        // backpressure until full, then oldest-first drain
        fifo_full = 1;
        for (int i = 0; i < 8; i++) disp(64'h30 + 64'(i), 0, 1, 0, 1, 0, 0);
        chk("full_disp_ready", disp_ready, 0);
        chk("full_occupancy", occupancy, 8);
        chk("full_no_issue", issue_valid, 0);
        disp(64'h99, 0, 1, 0, 1, 0, 0);
        chk("full_ignored_occ", occupancy, 8);
        fifo_full = 0;
        for (int i = 0; i < 8; i++) q.push_back('{64'h30 + 64'(i), cyc + i});
        drain(12);
        chk("after_drain_empty", empty, 1);

        // flush with concurrent dispatch
        fifo_full = 1;
        for (int i = 0; i < 4; i++) disp(64'h40 + 64'(i), 0, 1, 0, 1, 0, 0);
        chk("pre_flush_occ", occupancy, 4);
        fifo_full = 0; flush = 1;
        disp_valid = 1; disp_payload = 64'hF1;
        disp_src1_rdy = 1; disp_src2_rdy = 1;
        #1 chk("flush_issue_valid", issue_valid, 0);
        tick;
        flush = 0; disp_valid = 0;
        chk("post_flush_occ", occupancy, 0);
        chk("post_flush_empty", empty, 1);
        chk("post_flush_ready", disp_ready, 1);
        repeat (4) tick;

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) disp(64'h50 + 64'(i), 6'(30 + i), 0, 0, 1, 0, 0);
        chk("pre_rst_occ", occupancy, 3);
        chk("pre_rst_empty", empty, 0);
        #2 rst_n = 0;
        #1;
        chk("async_rst_issue", issue_valid, 0);
        chk("async_rst_empty", empty, 1);
        chk("async_rst_ready", disp_ready, 1);
        chk("async_rst_occ", occupancy, 0);
        #10 rst_n = 1;
        repeat (3) tick;
        chk("final_queue", 64'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
